// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame format and transmitter state encoding
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_DELAY_FRAMES = 234;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte push handshake between client logic and the transmitter
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and head-of-queue read data
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; emptiness comes from count alone.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter, LSB first, back-to-back frames
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter  int FIFO_DEPTH   = 8,
    localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  host,
    output logic           uart_tx,
    output logic           busy,
    output logic [CW-1:0]  fifo_count
);

    localparam int TW = $clog2(DELAY_FRAMES);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] LAST_CYCLE = TW'(DELAY_FRAMES - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 line_q, line_d;

    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] head;

    assign host.tx_ready = !full;
    assign push          = host.tx_valid && !full;
    assign uart_tx       = line_q;
    assign busy          = (state_q != IDLE) || !empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (host.tx_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        line_d  = line_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    line_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == LAST_CYCLE) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    line_d  = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CYCLE) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift right so the next bit is always at index 1 before the shift.
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                        line_d  = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (cnt_q == LAST_CYCLE) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        line_d  = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
